// File: rtl/mux4_rr_pkg.sv
// Shared definitions for the 4-to-1 round-robin collector and its companion 1-to-4 demux.
// Channel index constants live here so that both blocks agree on the sel encoding.
package mux4_rr_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

    // One-hot vector with bit 'sel' set.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/mux4_rr_arb.sv
// Combinational 4-way round-robin arbiter.
// The search starts at ptr and wraps, so ptr holds the highest priority this cycle.
module rr_arb4
    import mux4_rr_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    logic [SEL_W-1:0] cand;

    // Scan from the lowest priority offset up, so the nearest requester after ptr is the last one kept.
    always_comb begin
        gnt_idx = ptr;
        any_gnt = 1'b0;
        cand    = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                gnt_idx = cand;
                any_gnt = 1'b1;
            end
        end
        gnt = any_gnt ? sel_onehot(gnt_idx) : '0;
    end

endmodule

// File: rtl/mux4_rr.sv
// Four-channel to one-channel collector with round-robin arbitration.
// Output is a single register stage; each word carries its source index on out_sel
// so a downstream 1-to-4 demux can route it back.
module mux4_rr
    import mux4_rr_pkg::*;
#(
    parameter int DATA_W = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [DATA_W-1:0] in2_data,
    input  logic [DATA_W-1:0] in3_data,
    input  logic [NUM_CH-1:0] in_valid,
    output logic [NUM_CH-1:0] in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic              load;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any_gnt;
    logic [DATA_W-1:0] mux_data_p0;

    logic [DATA_W-1:0] data_p1;
    logic [SEL_W-1:0]  sel_p1;
    logic              vld_p1;

    // The output register can take a new word when empty or when its word leaves this cycle.
    assign load = !vld_p1 || out_ready;
    assign req  = load ? in_valid : '0;

    rr_arb4 u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // No channel may transfer while reset is held, even though the arbiter still evaluates.
    assign in_ready = rst ? '0 : gnt;

    // Select the granted channel's word.
    always_comb begin
        mux_data_p0 = in0_data;
        case (gnt_idx)
            CH0:     mux_data_p0 = in0_data;
            CH1:     mux_data_p0 = in1_data;
            CH2:     mux_data_p0 = in2_data;
            CH3:     mux_data_p0 = in3_data;
            default: mux_data_p0 = in0_data;
        endcase
    end

    // Output register and round-robin pointer; ptr advances past the winner only on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
        end else if (load) begin
            vld_p1 <= any_gnt;
            if (any_gnt) begin
                data_p1 <= mux_data_p0;
                sel_p1  <= gnt_idx;
                ptr     <= gnt_idx + SEL_W'(1);
            end
        end
    end

    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux4_rr.sv
// Testbench for mux4_rr: directed steps with a reference round-robin model and a scoreboard queue.
module tb_mux4_rr;

    localparam int DATA_W = 2;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] din [4];
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;
    logic              out_valid;
    logic              out_ready;

    int n_pass;
    int n_total;

    logic [1:0] m_ptr;
    logic       m_vld;
    logic [3:0] sb [$];

    mux4_rr #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (din[0]),
        .in1_data  (din[1]),
        .in2_data  (din[2]),
        .in3_data  (din[3]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference grant: rotate requests so ptr sits at bit 0, take the lowest set bit.
    function automatic int model_grant(input logic [3:0] v, input logic [1:0] p);
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {v, v} >> p;
        rot = dbl[3:0];
        for (int j = 0; j < 4; j++)
            if (rot[j]) return (int'(p) + j) % 4;
        return -1;
    endfunction

    // Companion 1-to-4 demux: output k carries the word when sel selects it, else 0.
    function automatic logic [DATA_W-1:0] demux_out(input int k, input logic [1:0] s,
                                                    input logic [DATA_W-1:0] d);
        return (int'(s) == k) ? d : '0;
    endfunction

    // One clock: check handshake against the model, score an output transfer, record a grant.
    task automatic cycle();
        int         g;
        logic       mload;
        logic [3:0] eg;
        logic [3:0] w;
        #1;
        mload = !m_vld || out_ready;
        g = -1;
        if (mload) g = model_grant(in_valid, m_ptr);
        eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("out_valid", 8'(out_valid), 8'(m_vld));
        chk("in_ready", 8'(in_ready), 8'(eg));
        if (out_valid && out_ready) begin
            chk("sb_has_word", 8'(sb.size() != 0), 8'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk("out_sel", 8'(out_sel), 8'(w[3:2]));
                chk("out_data", 8'(out_data), 8'(w[1:0]));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("demux%0d", k), 8'(demux_out(k, out_sel, out_data)),
                        8'((int'(w[3:2]) == k) ? w[1:0] : 2'b00));
            end
        end
        if (g >= 0) sb.push_back({2'(g), din[g]});
        if (mload) begin
            m_vld = (g >= 0);
            if (g >= 0) m_ptr = 2'(g + 1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        m_ptr    = 2'd0;
        m_vld    = 1'b0;
        rst      = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = 2'(k);

        // Reset state, with every channel requesting
        #1;
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_out_data", 8'(out_data), 8'd0);
        chk("rst_out_sel", 8'(out_sel), 8'd0);
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all four requesting
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_sel", 8'(out_sel), 8'(i % 4));
            chk("rr_data", 8'(out_data), 8'(i % 4));
        end
        in_valid = 4'b0000;
        cycle();

        // Backpressure: ch2 word held while out_ready is low
        in_valid = 4'b0100;
        cycle();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_data", 8'(out_data), 8'b10);
            chk("bp_sel", 8'(out_sel), 8'd2);
            chk("bp_valid", 8'(out_valid), 8'd1);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_next_sel", 8'(out_sel), 8'd3);
        in_valid = 4'b0000;
        cycle();

        // Pointer skip: ptr=1 after ch0, requests on ch0 and ch3
        in_valid = 4'b0001;
        cycle();
        in_valid = 4'b1001;
        #1;
        chk("skip_ready", 8'(in_ready), 8'b1000);
        #1;
        cycle();
        chk("skip_sel3", 8'(out_sel), 8'd3);
        cycle();
        chk("skip_sel0", 8'(out_sel), 8'd0);
        in_valid = 4'b0000;
        cycle();

        // Idle drain: single ch1 word, then nothing; ptr should stay at 2
        in_valid = 4'b0010;
        cycle();
        in_valid = 4'b0000;
        chk("drain_sel", 8'(out_sel), 8'd1);
        cycle();
        cycle();
        chk("drain_valid_low", 8'(out_valid), 8'd0);
        in_valid = 4'b0111;
        #1;
        chk("drain_ptr_grant", 8'(in_ready), 8'b0100);
        #1;
        cycle();
        in_valid = 4'b0000;
        cycle();

        // Asynchronous reset while a word is held
        in_valid = 4'b1111;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 8'(out_valid), 8'd0);
        chk("arst_out_sel", 8'(out_sel), 8'd0);
        chk("arst_out_data", 8'(out_data), 8'd0);
        chk("arst_in_ready", 8'(in_ready), 8'd0);
        sb.delete();
        m_ptr = 2'd0;
        m_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'b0001;
        #1;
        chk("post_rst_ready", 8'(in_ready), 8'b0001);
        #1;
        cycle();
        in_valid = 4'b0000;
        cycle();

        // Loopback through the demux with distinct data and random downstream stalls
        din[0] = 2'd3;
        din[1] = 2'd2;
        din[2] = 2'd1;
        din[3] = 2'd0;
        in_valid = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("sb_empty", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
